wb_dual_master_arbiter: RTL and testbench
=========================================

Name: wb_dual_master_arbiter

Overview:
- Shares one internal Wishbone target bus between two masters inside the user project.
  - Master 0: the management SoC Wishbone slave port (wbs_*).
  - Master 1: a debug master driven from logic-analyzer bits, so the register space stays reachable if the management path is corrupted.
- Round-robin arbitration with bus lock while the owner holds cyc.
- Optional watchdog that terminates hung target accesses.

Parameters:
- AW, 32, address width.
- DW, 32, data width; sel width = DW/8.
- TIMEOUT_CYC, 255, cycles of stb-without-ack before forced termination; legal range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out access.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master 0 control
- wbs_sel_i  in  DW/8  master 0 byte select
- wbs_adr_i  in  AW  master 0 address
- wbs_dat_i  in  DW  master 0 write data
- wbs_ack_o  out  1  master 0 ack
- wbs_dat_o  out  DW  master 0 read data
- dbg_cyc_i, dbg_stb_i, dbg_we_i, dbg_sel_i, dbg_adr_i, dbg_dat_i  in  as master 0  master 1 request
- dbg_ack_o  out  1  master 1 ack
- dbg_dat_o  out  DW  master 1 read data
- s_cyc_o, s_stb_o, s_we_o  out  1 each  target control
- s_sel_o  out  DW/8  target byte select
- s_adr_o  out  AW  target address
- s_dat_o  out  DW  target write data
- s_ack_i  in  1  target ack
- s_dat_i  in  DW  target read data
- grant_o  out  2  one-hot current owner; 00 when idle
- timeout_o  out  1  one-cycle pulse on forced termination

Behaviour:
- States: IDLE, OWN0, OWN1. Register last_owner resets to 1, so master 0 wins the first tie.
- Reset: state=IDLE, grant_o=00, timeout_o=0, counter=0. All s_* outputs, wbs_ack_o/dbg_ack_o and wbs_dat_o/dbg_dat_o are 0 while idle.
- Reset asserted mid-access: the access is abandoned immediately. The next cycle shows IDLE outputs and no ack is issued.
- IDLE arbitration:
  - Only one cyc high: grant that master.
  - Both cyc high: grant the master that is not last_owner.
  - The grant is registered. s_cyc_o rises the cycle after the request is sampled (1-cycle arbitration latency).
- OWNx routing:
  - Owner's request fields go combinationally to s_*.
  - s_ack_i and s_dat_i route to the owner only.
  - Non-owner always sees ack=0, dat=0. Its request stays pending with no timeout of its own.
- Lock and release:
  - Grant holds while the owner's cyc=1, including multiple stb/ack beats.
  - When the owner's cyc=0 is sampled: last_owner←x, go to IDLE (one dead cycle). Re-arbitrate in IDLE.
  - A master may not be re-granted back-to-back while the other's cyc is high.
- Owner drops cyc with stb outstanding: s_cyc_o/s_stb_o drop the same cycle. A late s_ack_i is ignored.
- Acks are passed through unmodified. The target owns single-cycle ack semantics. s_ack_i while s_stb_o=0 is dropped.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - Counter clears each cycle that s_stb_o=0 or s_ack_i=1, otherwise increments.
  - When counter==TIMEOUT_CYC-1 and no ack: owner ack=1 for that cycle, owner read data=ERR_DATA, timeout_o=1, counter clears.
  - s_stb_o is forced 0 the following cycle only. A later real s_ack_i for that beat is discarded while the force is active.
- Without the macro: no counter, timeout_o tied 0, hung target stalls the owner indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE/OWN0/OWN1);
  - the owner index type;
  - the ERR_DATA default;
  - TIMEOUT_W = $clog2(65536).
- One sub-module: wb_arb_watchdog (counter plus expiry pulse), instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Master 0 write: wbs_cyc/stb/we=1, adr=0x3000_0004, dat=0x1234_5678; target acks 2 cycles after s_stb_o → s_* mirror the request from cycle 1, wbs_ack_o=1 for exactly one cycle, grant_o=01, dbg_ack_o stays 0.
- Simultaneous cyc from both masters out of reset → master 0 granted first; after its cyc drops and one IDLE cycle, grant_o=10. Repeat the pair → grants alternate 01,10,01,10.
- Master 1 holds cyc across 3 read beats returning 0xA, 0xB, 0xC while master 0 requests → master 0 is not granted until master 1's cyc falls; dbg_dat_o shows 0xA, 0xB, 0xC on its ack cycles.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYC=8, target never acks → owner ack and timeout_o pulse after 8 stb cycles, read data 0xDEAD_BEEF, s_stb_o low the next cycle; without the macro, no ack after 1000 cycles.
- wb_rst_i asserted during an OWN1 access → next cycle grant_o=00, all s_* and acks 0; after release, simultaneous request grants master 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the dual-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned TIMEOUT_W    = $clog2(65536);

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stalled-beat watchdog: counts stb-without-ack cycles and pulses expire once
// per hung beat, then holds force_low for one cycle to retire that beat.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic expire,
  output logic force_low
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] cnt;

  assign expire = stb && !ack && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      force_low <= 1'b0;
    end else begin
      force_low <= expire;
      if (!stb || ack || expire) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone target between the management port
// and a debug master. Define WB_ARB_TIMEOUT_EN to enable the hung-access watchdog.
module wb_dual_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned     AW          = 32,
  parameter int unsigned     DW          = 32,
  parameter int unsigned     TIMEOUT_CYC = 255,
  parameter logic [DW-1:0]   ERR_DATA    = DW'(ERR_DATA_DEF)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [DW/8-1:0]   wbs_sel_i,
  input  logic [AW-1:0]     wbs_adr_i,
  input  logic [DW-1:0]     wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DW-1:0]     wbs_dat_o,
  input  logic              dbg_cyc_i,
  input  logic              dbg_stb_i,
  input  logic              dbg_we_i,
  input  logic [DW/8-1:0]   dbg_sel_i,
  input  logic [AW-1:0]     dbg_adr_i,
  input  logic [DW-1:0]     dbg_dat_i,
  output logic              dbg_ack_o,
  output logic [DW-1:0]     dbg_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_dat_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  arb_state_t state;
  owner_t     last_owner;
  logic [1:0] grant_q;
  logic       expire;
  logic       force_low;
  logic       owner_ack;
  logic [DW-1:0] rd_data;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the master that did not own the bus last wins.
          if (wbs_cyc_i && (!dbg_cyc_i || last_owner)) begin
            state   <= OWN0;
            grant_q <= 2'b01;
          end else if (dbg_cyc_i) begin
            state   <= OWN1;
            grant_q <= 2'b10;
          end
        end
        OWN0: if (!wbs_cyc_i) begin
          state      <= IDLE;
          grant_q    <= '0;
          last_owner <= 1'b0;
        end
        OWN1: if (!dbg_cyc_i) begin
          state      <= IDLE;
          grant_q    <= '0;
          last_owner <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (state == OWN0) begin
      s_cyc_o = wbs_cyc_i;
      s_stb_o = wbs_cyc_i && wbs_stb_i && !force_low;
      s_we_o  = wbs_we_i;
      s_sel_o = wbs_sel_i;
      s_adr_o = wbs_adr_i;
      s_dat_o = wbs_dat_i;
    end else if (state == OWN1) begin
      s_cyc_o = dbg_cyc_i;
      s_stb_o = dbg_cyc_i && dbg_stb_i && !force_low;
      s_we_o  = dbg_we_i;
      s_sel_o = dbg_sel_i;
      s_adr_o = dbg_adr_i;
      s_dat_o = dbg_dat_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .stb       (s_stb_o),
    .ack       (s_ack_i),
    .expire    (expire),
    .force_low (force_low)
  );
  assign timeout_o = expire && !wb_rst_i;
`else
  assign expire    = 1'b0;
  assign force_low = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Acks outside a live strobe (late, or during the forced-low cycle) are dropped.
  assign owner_ack = ((s_stb_o && s_ack_i) || expire) && !wb_rst_i;
  assign rd_data   = expire ? ERR_DATA : s_dat_i;

  assign wbs_ack_o = (state == OWN0) && owner_ack;
  assign dbg_ack_o = (state == OWN1) && owner_ack;
  assign wbs_dat_o = (state == OWN0) ? rd_data : '0;
  assign dbg_dat_o = (state == OWN1) ? rd_data : '0;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter with a latency-programmable target.
module tb_wb_dual_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat;
  logic        wbs_ack;
  logic [31:0] wbs_rdat;
  logic        dbg_cyc, dbg_stb, dbg_we;
  logic [3:0]  dbg_sel;
  logic [31:0] dbg_adr, dbg_dat;
  logic        dbg_ack;
  logic [31:0] dbg_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic [1:0]  grant;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  int          tgt_lat;
  int          tgt_cnt;
  logic [31:0] rd_tbl [4];
  int          rd_idx;
  logic        rd_clr;

  always #5 clk = ~clk;

  wb_dual_master_arbiter #(
    .AW          (32),
    .DW          (32),
    .TIMEOUT_CYC (8),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (wbs_cyc),
    .wbs_stb_i (wbs_stb),
    .wbs_we_i  (wbs_we),
    .wbs_sel_i (wbs_sel),
    .wbs_adr_i (wbs_adr),
    .wbs_dat_i (wbs_dat),
    .wbs_ack_o (wbs_ack),
    .wbs_dat_o (wbs_rdat),
    .dbg_cyc_i (dbg_cyc),
    .dbg_stb_i (dbg_stb),
    .dbg_we_i  (dbg_we),
    .dbg_sel_i (dbg_sel),
    .dbg_adr_i (dbg_adr),
    .dbg_dat_i (dbg_dat),
    .dbg_ack_o (dbg_ack),
    .dbg_dat_o (dbg_rdat),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dat),
    .s_ack_i   (s_ack),
    .s_dat_i   (s_rdat),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  // Target: acks each strobed beat tgt_lat cycles after it starts (0 = never).
  always @(posedge clk) begin
    if (rst || rd_clr) rd_idx <= 0;
    if (rst || !s_stb || s_ack) begin
      s_ack   <= 1'b0;
      s_rdat  <= '0;
      tgt_cnt <= 0;
    end else if (tgt_lat > 0 && tgt_cnt + 1 >= tgt_lat) begin
      s_ack   <= 1'b1;
      s_rdat  <= rd_tbl[rd_idx % 4];
      rd_idx  <= rd_idx + 1;
      tgt_cnt <= 0;
    end else begin
      tgt_cnt <= tgt_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Polls for the given master's ack; flags any non-owner ack or grant change.
  task automatic wait_ack(input int m, input int budget, output logic [31:0] d,
                          output int n, output bit to_seen, output bit stray);
    bit got;
    got = 1'b0; d = '0; n = -1; to_seen = 1'b0; stray = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if ((m == 0 ? dbg_ack : wbs_ack) || grant != (m == 0 ? 2'b01 : 2'b10)) stray = 1'b1;
      if (m == 0 ? wbs_ack : dbg_ack) begin
        got = 1'b1;
        n = i;
        d = (m == 0) ? wbs_rdat : dbg_rdat;
        to_seen = timeout;
      end
      step();
    end
  endtask

  // Both masters request together from IDLE: expect 01, dead cycle, then 10.
  task automatic serve_pair(input string tag);
    logic [31:0] d;
    int n;
    bit to, st;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0;
    dbg_cyc = 1; dbg_stb = 1; dbg_we = 0;
    @(negedge clk); check_eq({tag, "_idle"}, 32'(grant), 32'd0);
    step(); @(negedge clk); check_eq({tag, "_g0"}, 32'(grant), 32'd1);
    step(); wait_ack(0, 10, d, n, to, st);
    check_eq({tag, "_ack0_lat"}, n, 32'd1);
    check_eq({tag, "_stray0"}, 32'(st), 32'd0);
    wbs_cyc = 0; wbs_stb = 0;
    @(negedge clk); check_eq({tag, "_drop_cyc"}, 32'(s_cyc), 32'd0);
    step(); @(negedge clk); check_eq({tag, "_dead"}, 32'(grant), 32'd0);
    step(); @(negedge clk); check_eq({tag, "_g1"}, 32'(grant), 32'd2);
    step(); wait_ack(1, 10, d, n, to, st);
    check_eq({tag, "_ack1_lat"}, n, 32'd1);
    check_eq({tag, "_stray1"}, 32'(st), 32'd0);
    dbg_cyc = 0; dbg_stb = 0;
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] d;
    int n;
    bit to, st;

    rst = 1; rd_clr = 0; tgt_lat = 2;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = '0; wbs_adr = '0; wbs_dat = '0;
    dbg_cyc = 0; dbg_stb = 0; dbg_we = 0; dbg_sel = '0; dbg_adr = '0; dbg_dat = '0;
    rd_tbl[0] = 32'h0; rd_tbl[1] = 32'h0; rd_tbl[2] = 32'h0; rd_tbl[3] = 32'h0;

    // Reset state
    step(); step(); step();
    @(negedge clk);
    check_eq("rst_grant",   32'(grant),   32'd0);
    check_eq("rst_s_cyc",   32'(s_cyc),   32'd0);
    check_eq("rst_s_stb",   32'(s_stb),   32'd0);
    check_eq("rst_wbs_ack", 32'(wbs_ack), 32'd0);
    check_eq("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_wbs_dat", wbs_rdat,     32'd0);
    step(); rst = 0;
    step();

    // Master 0 write, target acks two cycles after strobe
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF;
    wbs_adr = 32'h3000_0004; wbs_dat = 32'h1234_5678;
    @(negedge clk); check_eq("m0w_arb_lat", 32'(s_cyc), 32'd0);
    step(); @(negedge clk);
    check_eq("m0w_grant", 32'(grant), 32'd1);
    check_eq("m0w_s_cyc", 32'(s_cyc), 32'd1);
    check_eq("m0w_s_stb", 32'(s_stb), 32'd1);
    check_eq("m0w_s_we",  32'(s_we),  32'd1);
    check_eq("m0w_s_sel", 32'(s_sel), 32'hF);
    check_eq("m0w_s_adr", s_adr,      32'h3000_0004);
    check_eq("m0w_s_dat", s_dat,      32'h1234_5678);
    step(); wait_ack(0, 10, d, n, to, st);
    check_eq("m0w_ack_lat", n, 32'd1);
    check_eq("m0w_no_dbg_ack", 32'(st), 32'd0);
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    @(negedge clk);
    check_eq("m0w_ack_once", 32'(wbs_ack), 32'd0);
    check_eq("m0w_release_stb", 32'(s_stb), 32'd0);
    step(); step();

    // Round-robin from a fresh reset
    rst = 1; step(); rst = 0;
    serve_pair("rr1");
    serve_pair("rr2");

    // Master 1 locks the bus across three read beats while master 0 waits
    rd_tbl[0] = 32'hA; rd_tbl[1] = 32'hB; rd_tbl[2] = 32'hC;
    rd_clr = 1; step(); rd_clr = 0; step();
    dbg_cyc = 1; dbg_stb = 1; dbg_we = 0;
    @(negedge clk);
    step(); @(negedge clk); check_eq("lk_g1", 32'(grant), 32'd2);
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0;
    step();
    wait_ack(1, 10, d, n, to, st);
    check_eq("lk_beat0", d, 32'hA); check_eq("lk_stray0", 32'(st), 32'd0);
    wait_ack(1, 10, d, n, to, st);
    check_eq("lk_beat1", d, 32'hB); check_eq("lk_stray1", 32'(st), 32'd0);
    wait_ack(1, 10, d, n, to, st);
    check_eq("lk_beat2", d, 32'hC); check_eq("lk_stray2", 32'(st), 32'd0);
    dbg_cyc = 0; dbg_stb = 0;
    @(negedge clk); check_eq("lk_drop_cyc", 32'(s_cyc), 32'd0);
    step(); @(negedge clk); check_eq("lk_dead", 32'(grant), 32'd0);
    step(); @(negedge clk); check_eq("lk_g0", 32'(grant), 32'd1);
    step(); wait_ack(0, 10, d, n, to, st);
    check_eq("lk_m0_ack_lat", n, 32'd1);
    wbs_cyc = 0; wbs_stb = 0;
    step(); step();

    // Hung target
    tgt_lat = 0;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0;
    @(negedge clk);
    step();
`ifdef WB_ARB_TIMEOUT_EN
    wait_ack(0, 20, d, n, to, st);
    check_eq("to_ack_lat", n, 32'd7);
    check_eq("to_err_data", d, 32'hDEAD_BEEF);
    check_eq("to_pulse", 32'(to), 32'd1);
    @(negedge clk);
    check_eq("to_force_stb", 32'(s_stb), 32'd0);
    check_eq("to_keep_cyc", 32'(s_cyc), 32'd1);
    check_eq("to_pulse_once", 32'(timeout), 32'd0);
    check_eq("to_no_ack", 32'(wbs_ack), 32'd0);
    step(); @(negedge clk);
    check_eq("to_resume_stb", 32'(s_stb), 32'd1);
`else
    wait_ack(0, 1000, d, n, to, st);
    check_eq("nto_no_ack", n, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("nto_stb_held", 32'(s_stb), 32'd1);
    check_eq("nto_no_timeout", 32'(timeout), 32'd0);
`endif
    wbs_cyc = 0; wbs_stb = 0;
    step(); step();
    tgt_lat = 3;

    // Reset during a master 1 access
    dbg_cyc = 1; dbg_stb = 1; dbg_we = 1; dbg_sel = 4'h3;
    dbg_adr = 32'h3000_0010; dbg_dat = 32'h5555_AAAA;
    @(negedge clk);
    step(); @(negedge clk); check_eq("rm_g1", 32'(grant), 32'd2);
    step(); rst = 1;
    @(negedge clk);
    step(); @(negedge clk);
    check_eq("rm_grant",   32'(grant),   32'd0);
    check_eq("rm_s_cyc",   32'(s_cyc),   32'd0);
    check_eq("rm_s_stb",   32'(s_stb),   32'd0);
    check_eq("rm_s_adr",   s_adr,        32'd0);
    check_eq("rm_s_dat",   s_dat,        32'd0);
    check_eq("rm_dbg_ack", 32'(dbg_ack), 32'd0);
    check_eq("rm_wbs_ack", 32'(wbs_ack), 32'd0);
    check_eq("rm_dbg_dat", dbg_rdat,     32'd0);
    step();
    rst = 0; dbg_cyc = 0; dbg_stb = 0; dbg_we = 0;
    tgt_lat = 2;
    step();
    serve_pair("rm_rr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
